// File: rtl/onehot_mon_pkg.sv
// rtl/onehot_mon_pkg.sv - shared types and constants for the one-hot decode monitor
// ONEHOT_MON_ERRCNT_EN: leave undefined by default; define it to build the error counter.
package onehot_mon_pkg;

  localparam int N_LINES = 8;
  localparam int CODE_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  function automatic logic [3:0] popcount8(input logic [N_LINES-1:0] w);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < N_LINES; i++) begin
      c = c + {3'b000, w[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/onehot_enc8.sv
// rtl/onehot_enc8.sv - combinational lowest-set-bit encoder with zero/multi flags
module onehot_enc8
  import onehot_mon_pkg::*;
(
  input  logic [N_LINES-1:0] word,
  output logic [CODE_W-1:0]  code,
  output logic               zero,
  output logic               multi
);

  logic [3:0] pop;

  assign pop   = popcount8(word);
  assign zero  = (pop == 4'd0);
  assign multi = (pop > 4'd1);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    code = '0;
    for (int i = N_LINES - 1; i >= 0; i--) begin
      if (word[i]) begin
        code = i[CODE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/onehot_decode_monitor.sv
// rtl/onehot_decode_monitor.sv - captures decoder words, re-encodes them and flags non-one-hot words
// ONEHOT_MON_ERRCNT_EN: builds the saturating error counter and err_clr; otherwise err_count is 0.
module onehot_decode_monitor #(
  parameter int N_LINES = 8,
  parameter int CODE_W  = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] dec_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [CODE_W-1:0]  code_out,
  output logic               err_zero,
  output logic               err_multi,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   err_count
);

  import onehot_mon_pkg::*;

  state_t             state;
  logic [N_LINES-1:0] word_q;
  logic [CODE_W-1:0]  enc_code;
  logic               enc_zero;
  logic               enc_multi;
  logic               err_event;

  onehot_enc8 u_enc (
    .word  (word_q),
    .code  (enc_code),
    .zero  (enc_zero),
    .multi (enc_multi)
  );

  assign err_event = (state == ST_CHECK) && (enc_zero || enc_multi);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      word_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      code_out  <= '0;
      err_zero  <= 1'b0;
      err_multi <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            word_q   <= dec_in;
            in_ready <= 1'b0;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          code_out  <= enc_code;
          err_zero  <= enc_zero;
          err_multi <= enc_multi;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          // Result stays put until the consumer takes it; no overlap with a new accept.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ONEHOT_MON_ERRCNT_EN
  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_count <= '0;
    end else if (err_event && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end
`else
  logic unused_errcnt;
  assign unused_errcnt = err_clr ^ err_event;
  assign err_count     = '0;
`endif

endmodule

// File: tb/tb_onehot_decode_monitor.sv
// tb/tb_onehot_decode_monitor.sv - directed self-checking bench for onehot_decode_monitor
module tb_onehot_decode_monitor;

`ifdef ONEHOT_MON_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dec_in;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] code_out;
  logic       err_zero;
  logic       err_multi;
  logic       out_valid;
  logic       out_ready;
  logic       err_clr;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  onehot_decode_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .dec_in    (dec_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .code_out  (code_out),
    .err_zero  (err_zero),
    .err_multi (err_multi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one word through accept, CHECK and OUT; bp leaves out_ready low in OUT.
  task automatic send(input logic [7:0] w, input logic [2:0] ecode, input bit ez, input bit em,
                      input bit bp, input bit clr_in_check, input bit full);
    int t;
    t = 0;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    dec_in    = w;
    in_valid  = 1'b1;
    out_ready = !bp;
    tick();
    in_valid = 1'b0;
    dec_in   = ~w;
    if (clr_in_check) err_clr = 1'b1;
    if (full) begin
      check("check_no_valid", {31'd0, out_valid}, 32'd0);
      check("check_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    if (clr_in_check) exp_cnt = 0;
    else if (CNT_EN && (ez || em) && exp_cnt != 255) exp_cnt++;
    tick();
    err_clr = 1'b0;
    check("out_valid_n2", {31'd0, out_valid}, 32'd1);
    check("code_out", {29'd0, code_out}, {29'd0, ecode});
    check("err_zero", {31'd0, err_zero}, {31'd0, ez});
    check("err_multi", {31'd0, err_multi}, {31'd0, em});
    if (full) check("err_count", {24'd0, err_count}, exp_cnt);
    if (!bp) begin
      tick();
      if (full) begin
        check("out_valid_drop", {31'd0, out_valid}, 32'd0);
        check("in_ready_back", {31'd0, in_ready}, 32'd1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dec_in = '0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    check("rst_code_out", {29'd0, code_out}, 32'd0);
    check("rst_flags", {30'd0, err_zero, err_multi}, 32'd0);

    for (int k = 0; k < 8; k++) begin
      logic [7:0] w;
      w = 8'd1 << k;
      send(w, k[2:0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    send(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send(8'h24, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("err_count_two", {24'd0, err_count}, CNT_EN ? 32'd2 : 32'd0);

    send(8'h10, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      dec_in = 8'h5A ^ c[7:0];
      tick();
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_code_out", {29'd0, code_out}, 32'd4);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

    for (int n = 0; n < 260; n++) begin
      send(8'hFF, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("sat_count", {24'd0, err_count}, CNT_EN ? 32'd255 : 32'd0);

    send(8'hFF, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("clr_wins", {24'd0, err_count}, 32'd0);

    dec_in = 8'h03; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("midflight_no_valid", {31'd0, out_valid}, 32'd0);
      check("midflight_count", {24'd0, err_count}, 32'd0);
      tick();
    end
    check("midflight_in_ready", {31'd0, in_ready}, 32'd1);

    send(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("count_after_reset", {24'd0, err_count}, CNT_EN ? 32'd1 : 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/onehot_decode_monitor.md
# onehot_decode_monitor

Downstream consumer of the 3-to-8 line decoder. Registers each 8-bit decoder output word, checks that exactly one line is asserted, and re-encodes it to a 3-bit code. Returns the code with error flags over a valid/ready handshake. Lets a bench or on-chip self-test close the loop around the decoder without comparing the outputs by hand.

## Interface
Parameters:
- `N_LINES`, default 8: decoder output width; fixed at 8 in this revision.
- `CODE_W`, default 3: encoded code width, equal to log2(N_LINES).
- `CNT_W`, default 8: error counter width.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `dec_in`, input, 8: decoder output word; bit k asserted means code k.
- `in_valid`, input, 1: `dec_in` is valid.
- `in_ready`, output, 1: the block accepts a word this cycle.
- `code_out`, output, 3: re-encoded code.
- `err_zero`, output, 1: no line was asserted in the captured word.
- `err_multi`, output, 1: two or more lines were asserted.
- `out_valid`, output, 1: `code_out` and the error flags are valid.
- `out_ready`, input, 1: the consumer takes the result.
- `err_clr`, input, 1: clears the error counter.
- `err_count`, output, CNT_W: saturating count of erroneous words.

## Operation
- The FSM has three states: IDLE, CHECK, OUT.
- IDLE:
  - `in_ready`=1.
  - When `in_valid` is high, `dec_in` is captured into `word_q` and the FSM goes to CHECK.
- CHECK (one cycle):
  - Compute the population count of `word_q`.
  - Compute `code` as the index of the lowest set bit, or 0 if no bit is set.
  - Register `code_out`, `err_zero` (popcount==0) and `err_multi` (popcount>=2).
  - Go to OUT.
- OUT:
  - `out_valid`=1, and the outputs are held stable.
  - When `out_ready` is high, go to IDLE.
  - A new word cannot be accepted in the same cycle.
- Error counter:
  - It increments by 1 when the FSM leaves CHECK with `err_zero` or `err_multi` set.
  - It saturates at 2^CNT_W−1 and does not wrap.
  - `err_clr` sets it to 0. If `err_clr` and an increment occur in the same cycle, the clear wins and that event is not counted.
- `in_ready` is low in CHECK and OUT. Upstream must hold `dec_in` and `in_valid` until accepted.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `code_out`=0, `err_zero`=0, `err_multi`=0, `err_count`=0.
- Latency: accept at edge N, CHECK at N+1, `out_valid` high from N+2.
- Minimum period between accepts is 3 cycles when `out_ready` is tied high.
- `rst` asserted in any state forces the reset values at the next edge. A word that is mid-flight is discarded and not counted.
- `out_valid` never drops without an `out_ready` handshake except on reset.
- `dec_in` is sampled only on the accept edge. Changes in any other cycle are ignored.

## Configuration
- `ONEHOT_MON_ERRCNT_EN` defined: the error counter and `err_clr` logic are built as described above.
- Not defined:
  - The counter register is removed and `err_count` is tied to 0.
  - `err_clr` is ignored.
  - The flags and handshake are unchanged.

## Structure
- Package `onehot_mon_pkg` holds:
  - the state enum (IDLE, CHECK, OUT);
  - `N_LINES` and `CODE_W` constants;
  - the `ONEHOT_MON_ERRCNT_EN` default comment.
- Sub-module `onehot_enc8` is purely combinational. It takes an 8-bit word and produces the lowest-set-bit index (3 bits), a zero flag and a multi flag.
- The top level instantiates `onehot_enc8` on `word_q` and holds the FSM, output registers and counter.

## Test plan
- Reset check: assert `rst` for 2 cycles, then release. Require `in_ready`=1, `out_valid`=0 and `err_count`=0.
- Sweep: present `dec_in`=8'b0000_0001 through 8'b1000_0000 in order, with `out_ready` held high. Require `code_out`=0..7 respectively, no error flags, and each `out_valid` exactly 2 cycles after accept.
- Error words:
  - `dec_in`=8'h00: require `err_zero`=1 and `code_out`=0.
  - `dec_in`=8'h24: require `err_multi`=1 and `code_out`=2.
  - After both words, `err_count`=2.
- Backpressure: hold `out_ready`=0 for 5 cycles with `dec_in`=8'h10.
  - Require `out_valid` and `code_out`=4 stable throughout, and `in_ready`=0.
  - Raise `out_ready`: require `in_ready` back to 1 the next cycle.
- Saturation and clear: send 260 erroneous words (8'hFF). Require `err_count`=255.
  - Assert `err_clr` in the same cycle as an error increment: require `err_count`=0.
- Mid-flight reset: assert `rst` during CHECK of word 8'h03. Require `out_valid` never rises and `err_count` stays unchanged.
